// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle: pipeline W stage, long-latency unit handshake,
// register-file write port and status toward fetch/decode.
interface wb_port_arbiter_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  // Pipeline write-back stage
  logic            pipe_we;
  logic [4:0]      pipe_rd;
  logic [31:0]     pipe_data;

  // Long-latency unit result handshake
  logic            lu_valid;
  logic            lu_ready;
  logic [4:0]      lu_rd;
  logic [31:0]     lu_data;

  // Register-file write port
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [31:0]     rf_data;

  // Status
  logic            stall_req;
  logic [CntW-1:0] pending_cnt;

  // Arbiter side
  modport slave (
    input  pipe_we, pipe_rd, pipe_data,
    input  lu_valid, lu_rd, lu_data,
    output lu_ready,
    output rf_we, rf_rd, rf_data,
    output stall_req, pending_cnt
  );

  // Producer / consumer side
  modport master (
    output pipe_we, pipe_rd, pipe_data,
    output lu_valid, lu_rd, lu_data,
    input  lu_ready,
    input  rf_we, rf_rd, rf_data,
    input  stall_req, pending_cnt
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. The in-order pipeline always owns the
// port; out-of-order long-latency results are parked in a small FIFO and
// drained into idle port cycles. Results overwritten by a younger pipeline
// write to the same register are killed in place and silently popped.
module wb_port_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);

  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  localparam logic [CntW-1:0]  DepthC   = CntW'(DEPTH);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);
  localparam logic [PtrW-1:0]  PtrOne   = PtrW'(1);
  localparam logic [WaitW-1:0] MaxWaitC = WaitW'(MAX_WAIT);
  localparam logic [WaitW-1:0] WaitOne  = WaitW'(1);

  // FIFO storage. Valid bits of unoccupied slots are kept at zero so that
  // "any valid entry" is a plain OR-reduction.
  logic [4:0]       ent_rd_q   [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [DEPTH-1:0] ent_valid_q, ent_valid_d;

  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WaitW-1:0] wait_q, wait_d;

  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_rd_q, rf_rd_d;
  logic [31:0]      rf_data_q, rf_data_d;

  logic lu_ready;
  logic pw;
  logic acc;
  logic occupied;
  logic head_valid;
  logic any_valid;
  logic grant_head;
  logic bypass;
  logic pop;
  logic enq;
  logic enq_valid;

  // Handshake and arbitration decode from current state and inputs.
  always_comb begin
    pw         = bus.pipe_we && (bus.pipe_rd != 5'd0);
    lu_ready   = (count_q < DepthC);
    acc        = bus.lu_valid && lu_ready;
    occupied   = (count_q != '0);
    head_valid = occupied && ent_valid_q[rptr_q];
    any_valid  = |ent_valid_q;
    grant_head = !pw && head_valid;
    // Bypass only when nothing valid is queued, so ordering among LU results is kept.
    bypass     = !pw && !any_valid && acc && (bus.lu_rd != 5'd0);
    // A valid head leaves only when granted; a killed head always leaves.
    pop        = occupied && (grant_head || !ent_valid_q[rptr_q]);
    enq        = acc && (bus.lu_rd != 5'd0) && !bypass;
    // A result retiring alongside a younger pipeline write to the same rd is stale.
    enq_valid  = !(pw && (bus.lu_rd == bus.pipe_rd));
  end

  // Port winner selection; the write is registered for the next cycle.
  always_comb begin
    rf_we_d   = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (pw) begin
      rf_we_d   = 1'b1;
      rf_rd_d   = bus.pipe_rd;
      rf_data_d = bus.pipe_data;
    end else if (grant_head) begin
      rf_we_d   = 1'b1;
      rf_rd_d   = ent_rd_q[rptr_q];
      rf_data_d = ent_data_q[rptr_q];
    end else if (bypass) begin
      rf_we_d   = 1'b1;
      rf_rd_d   = bus.lu_rd;
      rf_data_d = bus.lu_data;
    end
  end

  // FIFO bookkeeping: pop, WAW kill, enqueue, pointers and count.
  always_comb begin
    ent_valid_d = ent_valid_q;
    rptr_d      = rptr_q;
    wptr_d      = wptr_q;
    count_d     = count_q;

    if (pop) begin
      ent_valid_d[rptr_q] = 1'b0;
      rptr_d              = rptr_q + PtrOne;
    end

    if (pw) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent_rd_q[i] == bus.pipe_rd) begin
          ent_valid_d[i] = 1'b0;
        end
      end
    end

    // The tail slot is free (lu_ready), so this never clobbers a live entry.
    if (enq) begin
      ent_valid_d[wptr_q] = enq_valid;
      wptr_d              = wptr_q + PtrOne;
    end

    unique case ({enq, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  // Starvation counter: counts only cycles where a valid head loses to the pipeline.
  always_comb begin
    wait_d = '0;
    if (head_valid && pw) begin
      wait_d = (wait_q == MaxWaitC) ? wait_q : wait_q + WaitOne;
    end
  end

  // Control state and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid_q <= '0;
      rptr_q      <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      wait_q      <= '0;
      rf_we_q     <= 1'b0;
      rf_rd_q     <= 5'd0;
      rf_data_q   <= 32'd0;
    end else begin
      ent_valid_q <= ent_valid_d;
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      rf_we_q     <= rf_we_d;
      rf_rd_q     <= rf_rd_d;
      rf_data_q   <= rf_data_d;
    end
  end

  // Payload storage; contents are meaningless while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_rd_q[wptr_q]   <= bus.lu_rd;
      ent_data_q[wptr_q] <= bus.lu_data;
    end
  end

  assign bus.lu_ready    = lu_ready;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_rd       = rf_rd_q;
  assign bus.rf_data     = rf_data_q;
  assign bus.pending_cnt = count_q;
  assign bus.stall_req   = (count_q >= DepthC - CntOne) || (wait_q == MaxWaitC);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios followed by a random phase,
// all checked against a queue-based reference model of the arbitration rules.
module tb_wb_port_arbiter;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_WAIT = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(
    .DEPTH   (DEPTH),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          valid;
  } ent_t;

  // Reference model state
  ent_t        mq[$];
  int          m_wait;
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_wait = 0;
    m_we   = 1'b0;
    m_rd   = 5'd0;
    m_data = 32'd0;
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step(output bit accepted);
    bit   pw;
    bit   head_ok;
    bit   any_v;
    bit   bypass;
    ent_t e;
    pw       = bus.pipe_we && (bus.pipe_rd != 5'd0);
    accepted = bus.lu_valid && (mq.size() < DEPTH);
    head_ok  = (mq.size() > 0) && mq[0].valid;
    any_v    = 1'b0;
    foreach (mq[i]) if (mq[i].valid) any_v = 1'b1;
    bypass   = 1'b0;
    m_we     = 1'b0;
    if (pw) begin
      m_we = 1'b1; m_rd = bus.pipe_rd; m_data = bus.pipe_data;
    end else if (head_ok) begin
      m_we = 1'b1; m_rd = mq[0].rd; m_data = mq[0].data;
    end else if (!any_v && accepted && bus.lu_rd != 5'd0) begin
      bypass = 1'b1;
      m_we = 1'b1; m_rd = bus.lu_rd; m_data = bus.lu_data;
    end
    if (head_ok && pw) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
    else m_wait = 0;
    if (mq.size() > 0 && (!mq[0].valid || !pw)) void'(mq.pop_front());
    if (pw) begin
      foreach (mq[i]) begin
        if (mq[i].rd == bus.pipe_rd) begin
          e = mq[i]; e.valid = 1'b0; mq[i] = e;
        end
      end
    end
    if (accepted && bus.lu_rd != 5'd0 && !bypass) begin
      e.rd    = bus.lu_rd;
      e.data  = bus.lu_data;
      e.valid = !(pw && bus.lu_rd == bus.pipe_rd);
      mq.push_back(e);
    end
  endtask

  task automatic check_all(input string tag);
    bit exp_stall;
    exp_stall = (mq.size() >= DEPTH - 1) || (m_wait == MAX_WAIT);
    chk({tag, ".rf_we"},    32'(bus.rf_we),       32'(m_we));
    chk({tag, ".rf_rd"},    32'(bus.rf_rd),       32'(m_rd));
    chk({tag, ".rf_data"},  bus.rf_data,          m_data);
    chk({tag, ".pending"},  32'(bus.pending_cnt), 32'(mq.size()));
    chk({tag, ".lu_ready"}, 32'(bus.lu_ready),    32'(mq.size() < DEPTH));
    chk({tag, ".stall"},    32'(bus.stall_req),   32'(exp_stall));
  endtask

  task automatic step(input string tag, output bit accepted);
    model_step(accepted);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit pwe, input logic [4:0] prd, input logic [31:0] pdata,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ldata);
    bus.pipe_we   = pwe;
    bus.pipe_rd   = prd;
    bus.pipe_data = pdata;
    bus.lu_valid  = lv;
    bus.lu_rd     = lrd;
    bus.lu_data   = ldata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    bit          got;
    bit          lu_pend;
    logic [4:0]  lrd;
    logic [31:0] ldata;

    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Pipeline only
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    step("pipe", acc);
    chk("pipe.x5_data", bus.rf_data, 32'h1234);
    drive(1'b1, 5'd0, 32'hdead, 1'b0, 5'd0, 32'd0);
    step("pipe_rd0", acc);
    chk("pipe_rd0.we", 32'(bus.rf_we), 32'd0);

    // Bypass into an idle port
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hbeef);
    step("bypass", acc);
    chk("bypass.rd", 32'(bus.rf_rd), 32'd7);
    chk("bypass.data", bus.rf_data, 32'hbeef);
    chk("bypass.pending", 32'(bus.pending_cnt), 32'd0);

    // Contention: pipeline first, queued result next idle cycle
    drive(1'b1, 5'd1, 32'h55, 1'b1, 5'd9, 32'haa);
    step("cont0", acc);
    chk("cont0.rd", 32'(bus.rf_rd), 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step("cont1", acc);
    chk("cont1.rd", 32'(bus.rf_rd), 32'd9);
    chk("cont1.data", bus.rf_data, 32'haa);

    // Fill under continuous pipeline writes
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd2, 32'(i), 1'b1, 5'(10 + i), 32'(32'h100 + i));
      step("fill", acc);
    end
    chk("fill.pending", 32'(bus.pending_cnt), 32'd4);
    chk("fill.lu_ready", 32'(bus.lu_ready), 32'd0);
    chk("fill.stall", 32'(bus.stall_req), 32'd1);
    drive(1'b1, 5'd2, 32'h9, 1'b1, 5'd14, 32'h104);
    step("full_hold", acc);
    chk("full_hold.acc", 32'(acc), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'h104);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step("drain_acc", acc);
      if (acc) got = 1'b1;
    end
    chk("drain_acc.accepted", 32'(got), 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 6; i++) step("drain", acc);
    chk("drain.empty", 32'(bus.pending_cnt), 32'd0);

    // WAW kill
    drive(1'b1, 5'd20, 32'h77, 1'b1, 5'd3, 32'h11);
    step("waw_enq", acc);
    drive(1'b1, 5'd3, 32'h22, 1'b0, 5'd0, 32'd0);
    step("waw_pw", acc);
    chk("waw_pw.data", bus.rf_data, 32'h22);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step("waw_pop", acc);
    chk("waw_pop.we", 32'(bus.rf_we), 32'd0);
    chk("waw_pop.pending", 32'(bus.pending_cnt), 32'd0);
    step("waw_after", acc);
    chk("waw_after.data", bus.rf_data, 32'h22);

    // Starvation
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66);
    step("starve_enq", acc);
    drive(1'b1, 5'd4, 32'h45, 1'b0, 5'd0, 32'd0);
    for (int i = 1; i <= 9; i++) begin
      step("starve", acc);
      if (i == 7) chk("starve.lost7", 32'(bus.stall_req), 32'd0);
      if (i == 8) chk("starve.lost8", 32'(bus.stall_req), 32'd1);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step("starve_grant", acc);
    chk("starve_grant.rd", 32'(bus.rf_rd), 32'd6);
    chk("starve_grant.stall", 32'(bus.stall_req), 32'd0);

    // Random phase; LU holds its result until the model says it was accepted
    lu_pend = 1'b0;
    lrd     = 5'd0;
    ldata   = 32'd0;
    for (int c = 0; c < 400; c++) begin
      if (!lu_pend && $urandom_range(0, 99) < 50) begin
        lu_pend = 1'b1;
        lrd     = 5'($urandom_range(0, 7));
        ldata   = $urandom;
      end
      drive($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
            lu_pend, lrd, ldata);
      step("rand", acc);
      if (acc) lu_pend = 1'b0;
    end

    // Reset with buffered results, checked before any clock edge
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) step("pre_rst_drain", acc);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd8, 32'(i), 1'b1, 5'(16 + i), 32'(i));
      step("rst_load", acc);
    end
    chk("rst_load.pending", 32'(bus.pending_cnt), 32'd3);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_rst", acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
